// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and types for the PWM generator and the
//                PWM capture block (duty width, period, capture state enum).
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Default duty code width; the PWM period is 2**width clocks.
    localparam int unsigned c_DEFAULT_WIDTH  = 4;
    localparam int unsigned c_DEFAULT_PERIOD = 1 << c_DEFAULT_WIDTH;

    // Capture controller states.
    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_FLUSH   = 2'd1,
        CAP_ACQUIRE = 2'd2,
        CAP_LOCKED  = 2'd3
    } cap_state_e;

    // Period in clocks for a given duty code width.
    function automatic int unsigned period_of(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//                Asynchronous active-low reset, reset value 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures the high-time of an asynchronous PWM waveform over
//                fixed windows of 2**WIDTH clocks. After one discarded flush
//                window, every window publishes its duty count; two equal
//                consecutive results assert locked. A window high for every
//                cycle saturates duty and raises overrange.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             enable,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    output logic             locked,
    output logic             overrange
);

    localparam int unsigned      c_PERIOD   = period_of(WIDTH);
    localparam logic [WIDTH-1:0] c_WIN_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   c_FULL     = (WIDTH+1)'(c_PERIOD);

    logic             w_pwm_s;
    cap_state_e       r_state;
    cap_state_e       w_state_next;
    logic [WIDTH-1:0] r_win_cnt;
    logic [WIDTH:0]   r_high_cnt;
    logic [WIDTH:0]   w_result;
    logic [WIDTH:0]   r_prev_result;
    logic             r_prev_valid;
    logic             w_win_end;
    logic             w_publish;
    logic             w_sat;
    logic             w_halt;
    logic [WIDTH-1:0] r_duty;
    logic             r_duty_valid;
    logic             r_overrange;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pwm_in),
        .o_q   (w_pwm_s)
    );

    // The sample taken in the last window cycle belongs to that window, so it
    // is folded into the result here rather than lost across the wrap.
    assign w_win_end = (r_win_cnt == c_WIN_LAST);
    assign w_result  = r_high_cnt + {{WIDTH{1'b0}}, w_pwm_s};
    assign w_sat     = (w_result == c_FULL);
    assign w_halt    = !enable || (r_state == CAP_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and publish strobe; enable low overrides every state.
    always_comb begin
        w_state_next = r_state;
        w_publish    = 1'b0;
        if (!enable) begin
            w_state_next = CAP_IDLE;
        end else begin
            case (r_state)
                CAP_IDLE: begin
                    w_state_next = CAP_FLUSH;
                end
                CAP_FLUSH: begin
                    if (w_win_end) begin
                        w_state_next = CAP_ACQUIRE;
                    end
                end
                CAP_ACQUIRE: begin
                    if (w_win_end) begin
                        w_publish = 1'b1;
                        if (r_prev_valid && (w_result == r_prev_result)) begin
                            w_state_next = CAP_LOCKED;
                        end
                    end
                end
                CAP_LOCKED: begin
                    if (w_win_end) begin
                        w_publish = 1'b1;
                        if (w_result != r_prev_result) begin
                            w_state_next = CAP_ACQUIRE;
                        end
                    end
                end
                default: begin
                    w_state_next = CAP_IDLE;
                end
            endcase
        end
    end

    // Window and high counters; held clear while idle or disabled, and the
    // high counter restarts at window end with no gap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
        end else if (w_halt) begin
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
        end else begin
            r_win_cnt  <= r_win_cnt + WIDTH'(1);
            r_high_cnt <= w_win_end ? '0 : w_result;
        end
    end

    // Publish registers: duty and overrange hold between windows, and the
    // previous result is forgotten whenever measurement stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty        <= '0;
            r_duty_valid  <= 1'b0;
            r_overrange   <= 1'b0;
            r_prev_result <= '0;
            r_prev_valid  <= 1'b0;
        end else begin
            r_duty_valid <= w_publish;
            if (w_publish) begin
                r_duty        <= w_sat ? c_WIN_LAST : w_result[WIDTH-1:0];
                r_overrange   <= w_sat;
                r_prev_result <= w_result;
                r_prev_valid  <= 1'b1;
            end else if (w_halt) begin
                r_prev_valid  <= 1'b0;
            end
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_duty_valid;
    assign overrange  = r_overrange;
    assign locked     = (r_state == CAP_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Randomized self-checking bench for pwm_capture. A window
//                level reference model turns the applied pwm_in stream into
//                expected publications; a monitor checks them on duty_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int unsigned WIDTH  = 4;
    localparam int          PERIOD = 16;

    localparam int MODE_GEN  = 0;
    localparam int MODE_LOW  = 1;
    localparam int MODE_HIGH = 2;
    localparam int MODE_RAND = 3;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] duty;
    logic             duty_valid;
    logic             locked;
    logic             overrange;

    pwm_capture #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .enable     (enable),
        .duty       (duty),
        .duty_valid (duty_valid),
        .locked     (locked),
        .overrange  (overrange)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int duty;
        int ovr;
        int lck;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_d1, m_d2;
    bit m_run;
    int m_win[$];
    int m_wins_done;
    int m_prev;
    bit m_have_prev;
    int m_duty, m_ovr, m_lck;

    // Stimulus generator phase
    int gen_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pwm_in seen two clocks late, grouped into windows of
    // PERIOD samples from the first clock after enable is taken; window 0 of
    // each run is discarded, later windows are summed and published.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = 0; m_d2 = 0;
            m_run = 0;
            m_win.delete();
            m_wins_done = 0;
            m_have_prev = 0;
            m_prev = 0;
            m_duty = 0; m_ovr = 0; m_lck = 0;
            exp_q.delete();
        end else begin : model_step
            int   s;
            int   sum;
            exp_t e;
            s = m_d2;
            m_d2 = m_d1;
            m_d1 = int'(pwm_in);
            if (!enable) begin
                m_run = 0;
                m_lck = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_win.delete();
                m_wins_done = 0;
                m_have_prev = 0;
            end else begin
                m_win.push_back(s);
                if (m_win.size() == PERIOD) begin
                    sum = m_win.sum();
                    m_win.delete();
                    if (m_wins_done > 0) begin
                        e.ovr  = (sum == PERIOD) ? 1 : 0;
                        e.duty = (sum == PERIOD) ? PERIOD - 1 : sum;
                        e.lck  = (m_have_prev && sum == m_prev) ? 1 : 0;
                        m_prev = sum;
                        m_have_prev = 1;
                        m_duty = e.duty;
                        m_ovr  = e.ovr;
                        m_lck  = e.lck;
                        exp_q.push_back(e);
                    end
                    m_wins_done++;
                end
            end
        end
    end

    // Monitor: pops an expectation on every duty_valid and tracks held outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (duty_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got duty_valid=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("duty", duty, e.duty);
                    chk("overrange", overrange, e.ovr);
                    chk("locked_at_valid", locked, e.lck);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missed_valid", duty_valid, 1);
            end
            chk("locked_track", locked, m_lck);
            chk("duty_hold", duty, m_duty);
            chk("ovr_hold", overrange, m_ovr);
        end
    end

    task automatic drive(input int n, input int mode, input int d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (mode)
                MODE_GEN:  pwm_in = (gen_cnt < d);
                MODE_LOW:  pwm_in = 1'b0;
                MODE_HIGH: pwm_in = 1'b1;
                default:   pwm_in = 1'($urandom_range(0, 1));
            endcase
            gen_cnt = (gen_cnt + 1) % PERIOD;
        end
    endtask

    initial begin
        int mode;
        int dsel;
        int len;
        gen_cnt = int'($urandom_range(0, PERIOD - 1));
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ovr", overrange, 0);
        rst_n = 1'b1;

        // Steady duty 5: flush, publish, then lock.
        @(negedge clk);
        enable = 1'b1;
        drive(80, MODE_GEN, 5);
        chk("lock5_duty", duty, 5);
        chk("lock5_locked", locked, 1);

        // Duty changes to 9 and relocks.
        drive(80, MODE_GEN, 9);
        chk("lock9_duty", duty, 9);
        chk("lock9_locked", locked, 1);

        // Disable mid-window: locked clears, duty holds.
        drive(7, MODE_GEN, 9);
        enable = 1'b0;
        drive(3, MODE_GEN, 9);
        chk("dis_locked", locked, 0);
        chk("dis_duty", duty, 9);

        // Constant low then constant high.
        enable = 1'b1;
        drive(80, MODE_LOW, 0);
        chk("low_duty", duty, 0);
        chk("low_ovr", overrange, 0);
        chk("low_locked", locked, 1);
        drive(80, MODE_HIGH, 0);
        chk("high_duty", duty, PERIOD - 1);
        chk("high_ovr", overrange, 1);
        chk("high_locked", locked, 1);

        // Reset pulse mid-window while locked, then relock at the same value.
        drive(80, MODE_GEN, 7);
        drive(5, MODE_GEN, 7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_duty", duty, 0);
        chk("arst_valid", duty_valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_ovr", overrange, 0);
        drive(2, MODE_GEN, 7);
        rst_n = 1'b1;
        drive(80, MODE_GEN, 7);
        chk("relock_duty", duty, 7);
        chk("relock_locked", locked, 1);

        // Randomized segments with occasional enable drops.
        for (int it = 0; it < 16; it++) begin
            mode = int'($urandom_range(0, 3));
            dsel = int'($urandom_range(0, PERIOD - 1));
            len  = int'($urandom_range(20, 90));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                drive(int'($urandom_range(1, 5)), mode, dsel);
                enable = 1'b1;
            end
            drive(len, mode, dsel);
        end

        enable = 1'b0;
        drive(5, MODE_LOW, 0);
        chk("queue_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the duty code width; PERIOD is fixed at 2**WIDTH clocks, matching the PWM generator's counter period.
REQ-002 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 pwm_in  input  1  SHALL carry the PWM waveform under measurement; it is asynchronous to clk.
REQ-005 enable  input  1  SHALL start measurement while high; low SHALL stop and clear measurement.
REQ-006 duty  output  WIDTH  SHALL carry the last measured high-cycle count per window (0..PERIOD-1).
REQ-007 duty_valid  output  1  SHALL pulse high for one clock each time duty is updated.
REQ-008 locked  output  1  SHALL be high while two consecutive window results are equal.
REQ-009 overrange  output  1  SHALL be high when the last window was high for all PERIOD cycles.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; only the synchronized sample (pwm_s) SHALL be used; input-to-sample latency is 2 clocks.
REQ-011 The window counter (0..PERIOD-1) SHALL advance each clock in FLUSH/ACQUIRE/LOCKED and wrap from PERIOD-1 to 0.
REQ-012 The high counter (WIDTH+1 bits) SHALL increment on each clock with pwm_s=1 inside the window.
REQ-013 At window end (counter=PERIOD-1), result = high count + current pwm_s; the high counter SHALL then clear for the next window with no gap cycle.
REQ-014 If result=PERIOD, duty SHALL be PERIOD-1 (saturated) and overrange SHALL be 1; otherwise duty=result and overrange=0.
REQ-015 duty, overrange and duty_valid SHALL update on the clock after window end, so latency is 1 clock from window end.
REQ-016 States: IDLE, FLUSH, ACQUIRE, LOCKED.
REQ-017 IDLE->FLUSH when enable=1; entry SHALL clear the window and high counters.
REQ-018 FLUSH SHALL discard exactly one full window (no duty_valid), then go to ACQUIRE.
REQ-019 In ACQUIRE, each window SHALL publish duty; if result equals the previous window's result, the FSM SHALL go to LOCKED.
REQ-020 In LOCKED, a result differing from the previous result SHALL return the FSM to ACQUIRE; duty still updates with the new value.
REQ-021 locked SHALL be 1 exactly while the state is LOCKED (registered, same clock as that window's duty_valid).
REQ-022 enable=0 in any state SHALL force IDLE on the next clock, clear counters and locked, and hold duty/overrange; an in-progress window SHALL NOT be published.
REQ-023 A constant-low input SHALL yield duty=0, overrange=0 each window; constant high SHALL yield duty=PERIOD-1, overrange=1.

Reset
REQ-024 While rst_n=0: state=IDLE, synchronizer flops=0, counters=0, duty=0, duty_valid=0, locked=0, overrange=0.
REQ-025 Reset asserted mid-window SHALL take effect immediately and discard the partial window; after release the block SHALL wait in IDLE until enable is sampled high.

Structure
REQ-026 Shared package pwm_pkg SHALL hold WIDTH/PERIOD defaults and the capture state enum, shared with the PWM generator.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (1 bit, async active-low reset, reset value 0).

Verification
REQ-028 Generator alu_out=5, enable=1 -> first duty_valid after the FLUSH window with duty=5; next window duty=5 and locked=1.
REQ-029 pwm_in held 0 -> duty=0, overrange=0, locked=1 after 3 windows; pwm_in held 1 -> duty=15, overrange=1.
REQ-030 Locked at 5, generator changes to 9 -> locked drops on the first differing window, then duty=9 and locked=1 within 2 further windows.
REQ-031 enable dropped at window count 7 -> no duty_valid for that window, state IDLE next clock, duty holds 5, locked=0.
REQ-032 rst_n pulsed low mid-window while locked -> all outputs 0 immediately; after release with enable=1, FLUSH then relock at the same value.
REQ-033 pwm_in edge placed 1 clock before window end -> counted in the current window exactly once, with no double count across the wrap.
